// File: rtl/mmio_uart_fifo_if.sv
// CPU-side register bus for the MMIO UART: chip select, direction, address, data.
interface mmio_uart_fifo_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, output we, output addr, output din, input dout);
  modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo: bus-mapped UART with TX/RX FIFOs, sticky error flags and a maskable irq.
module mmio_uart_fifo #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_fifo_if.slave bus,
  output logic            tx,
  input  logic            rx,
  output logic            irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_PW = RX_AW + 1;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic wr_c, rd_c;
  assign wr_c = bus.cs & bus.we;
  assign rd_c = bus.cs & ~bus.we;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_PW-1:0]     tx_wp_q, tx_rp_q;
  logic                 tx_fifo_empty_c, tx_full_c, tx_wr_req_c, tx_push_c, tx_pop_c;
  logic                 tx_empty_c;

  tx_state_t            tx_st_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_q;

  assign tx_fifo_empty_c = (tx_wp_q == tx_rp_q);
  assign tx_full_c       = (tx_wp_q == {~tx_rp_q[TX_PW-1], tx_rp_q[TX_AW-1:0]});
  assign tx_wr_req_c     = wr_c & (bus.addr == 2'd0);
  // The serialiser pops when idle, or at the end of a stop bit for back-to-back frames.
  assign tx_pop_c        = ~tx_fifo_empty_c &
                           ((tx_st_q == TX_IDLE) | ((tx_st_q == TX_STOP) & (tx_cnt_q == CNT_LAST)));
  // A write to a full FIFO still lands if a pop frees a slot on the same edge.
  assign tx_push_c       = tx_wr_req_c & (~tx_full_c | tx_pop_c);
  assign tx_empty_c      = tx_fifo_empty_c & (tx_st_q == TX_IDLE);

  // TX FIFO storage (no reset needed, pointers qualify contents)
  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= bus.din[DATA_BITS-1:0];
  end

  // TX FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push_c) tx_wp_q <= tx_wp_q + TX_PW'(1);
      if (tx_pop_c)  tx_rp_q <= tx_rp_q + TX_PW'(1);
    end
  end

  // TX serialiser: start, DATA_BITS LSB-first, stop; every bit CLK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_st_q)
        TX_IDLE: begin
          if (tx_pop_c) begin
            tx_sh_q  <= tx_mem_q[tx_rp_q[TX_AW-1:0]];
            tx_q     <= 1'b0;
            tx_cnt_q <= '0;
            tx_st_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_q     <= tx_sh_q[0];
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_st_q  <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              tx_st_q <= TX_STOP;
            end else begin
              tx_q     <= tx_sh_q[1];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + BIT_W'(1);
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_pop_c) begin
              tx_sh_q <= tx_mem_q[tx_rp_q[TX_AW-1:0]];
              tx_q    <= 1'b0;
              tx_st_q <= TX_START;
            end else begin
              tx_st_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic rx_s1_q, rx_s2_q, rx_d3_q;

  rx_state_t            rx_st_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;

  logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_PW-1:0]     rx_wp_q, rx_rp_q;
  logic                 rx_fifo_empty_c, rx_full_c, rx_stop_mid_c, rx_push_req_c;
  logic                 rx_push_c, rx_pop_c, frm_set_c, rx_ovr_set_c;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_d3_q <= rx_s2_q;
    end
  end

  assign rx_fifo_empty_c = (rx_wp_q == rx_rp_q);
  assign rx_full_c       = (rx_wp_q == {~rx_rp_q[RX_PW-1], rx_rp_q[RX_AW-1:0]});
  assign rx_stop_mid_c   = (rx_st_q == RX_STOP) & (rx_cnt_q == CNT_LAST);
  assign rx_push_req_c   = rx_stop_mid_c & rx_s2_q;
  assign frm_set_c       = rx_stop_mid_c & ~rx_s2_q;
  assign rx_pop_c        = rd_c & (bus.addr == 2'd0) & ~rx_fifo_empty_c;
  // A CPU pop on the same edge frees room for a receive into a full FIFO.
  assign rx_push_c       = rx_push_req_c & (~rx_full_c | rx_pop_c);
  assign rx_ovr_set_c    = rx_push_req_c & rx_full_c & ~rx_pop_c;

  // RX deserialiser: midpoint start check, mid-bit sampling, back to idle at stop midpoint
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_d3_q & ~rx_s2_q) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) rx_st_q  <= RX_STOP;
            else                      rx_bit_q <= rx_bit_q + BIT_W'(1);
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push_c) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_sh_q;
  end

  // RX FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (rx_push_c) rx_wp_q <= rx_wp_q + RX_PW'(1);
      if (rx_pop_c)  rx_rp_q <= rx_rp_q + RX_PW'(1);
    end
  end

  // ---------------- registers, flags, read mux, irq ----------------
  logic [7:0] dout_q, rd_data_c, status_c;
  logic [1:0] ien_q;
  logic       tx_ovf_q, frm_err_q, rx_ovr_q, irq_q;
  logic       tx_ovf_d, frm_err_d, rx_ovr_d, irq_d, clr_c;

  assign clr_c     = wr_c & (bus.addr == 2'd1);
  // Set wins over a same-edge write-1-to-clear.
  assign tx_ovf_d  = (tx_wr_req_c & tx_full_c & ~tx_pop_c) | (tx_ovf_q  & ~(clr_c & bus.din[5]));
  assign frm_err_d = frm_set_c                             | (frm_err_q & ~(clr_c & bus.din[4]));
  assign rx_ovr_d  = rx_ovr_set_c                          | (rx_ovr_q  & ~(clr_c & bus.din[3]));
  assign irq_d     = (ien_q[0] & ~rx_fifo_empty_c) | (ien_q[1] & tx_empty_c);

  assign status_c  = {2'b00, tx_ovf_q, frm_err_q, rx_ovr_q, ~rx_fifo_empty_c, tx_empty_c, tx_full_c};

  // Read data selection
  always_comb begin
    rd_data_c = 8'h00;
    case (bus.addr)
      2'd0:    if (!rx_fifo_empty_c) rd_data_c = 8'(rx_mem_q[rx_rp_q[RX_AW-1:0]]);
      2'd1:    rd_data_c = status_c;
      2'd2:    rd_data_c = {6'b000000, ien_q};
      default: rd_data_c = 8'h00;
    endcase
  end

  // Control/status registers, registered read data and irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= 8'h00;
      ien_q     <= 2'b00;
      tx_ovf_q  <= 1'b0;
      frm_err_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tx_ovf_q  <= tx_ovf_d;
      frm_err_q <= frm_err_d;
      rx_ovr_q  <= rx_ovr_d;
      irq_q     <= irq_d;
      if (rd_c) dout_q <= rd_data_c;
      if (wr_c && (bus.addr == 2'd2)) ien_q <= bus.din[1:0];
    end
  end

  assign bus.dout = dout_q;
  assign tx       = tx_q;
  assign irq      = irq_q;

endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
Parametrised, bus-mapped UART for the fpga_6502 system. It replaces the fixed serial path with TX and RX FIFOs, a configurable bit period and word length, status and error flags, and a maskable interrupt. The block sits on the CPU data bus beside the RIOT and drives the board uartTx and uartRx pins.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; must be at least 4 and even.
TX_DEPTH, 8, TX FIFO entries; must be a power of 2 and at least 2.
RX_DEPTH, 8, RX FIFO entries; must be a power of 2 and at least 2.
DATA_BITS, 8, serial data bits per frame, 5 to 8.

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
cs  in  1  chip select, sampled on clk.
we  in  1  1 = write, 0 = read; qualified by cs.
addr  in  2  register select.
din  in  8  write data.
dout  out  8  registered read data.
tx  out  1  serial out; idles high.
rx  in  1  serial in, asynchronous to clk.
irq  out  1  active-high level interrupt.

Behaviour:
- Reset values (asynchronous): tx=1, dout=0x00, irq=0, both FIFOs empty, all sticky flags 0, IEN=0, both FSMs IDLE.
- Register map:
  - addr 0 write: push din[DATA_BITS-1:0] to the TX FIFO.
  - addr 0 read: pop the RX FIFO. Returns the data zero-extended to 8 bits, or 0x00 with no pop when the FIFO is empty.
  - addr 1 read: STATUS = {2'b0, tx_ovf, frm_err, rx_ovr, rx_avail, tx_empty, tx_full}.
  - addr 1 write: write-1-to-clear. din[3] clears rx_ovr, din[4] clears frm_err, din[5] clears tx_ovf.
  - addr 2 read/write: IEN. Bit0 enables rx_avail, bit1 enables tx_empty. Other bits read 0.
  - addr 3: reads 0x00; writes are ignored.
- Read latency: dout updates on the clk edge where cs & ~we is sampled, then holds until the next read. The pop happens on that same edge.
- TX FIFO:
  - A write when full drops the byte and sets tx_ovf.
  - If the TX FSM pops on the same edge as a write to a full FIFO, the write is accepted.
- TX FSM, states IDLE, START, DATA, STOP; each bit lasts exactly CLK_DIV cycles.
  - IDLE with the FIFO non-empty: pop and register tx=0 on the same edge.
  - A byte written into an empty FIFO on edge E drives tx low from edge E+1.
  - DATA sends DATA_BITS bits, LSB first. STOP drives tx=1 for one bit period.
  - From STOP, the FSM goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise it goes to IDLE.
  - tx_empty = FIFO empty AND FSM in IDLE.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - A falling edge of the synchronised rx in IDLE starts a count. At CLK_DIV/2 the line is rechecked; if it is high the start is treated as a glitch and the FSM returns to IDLE.
  - Data bits are sampled every CLK_DIV cycles after that midpoint, LSB first.
  - At the stop-bit midpoint: if rx=0, set frm_err and discard the byte. Otherwise push the byte; if the FIFO is full, drop it and set rx_ovr.
  - A CPU pop and a receiver push on the same edge with the FIFO full: both are performed.
  - The FSM returns to IDLE at the stop-bit midpoint, so it can resynchronise on the next start bit.
- Flag priority: a set and a CPU clear on the same edge leaves the flag set.
- irq = (IEN[0] & rx_avail) | (IEN[1] & tx_empty), registered, so it has 1 cycle of latency.
- FIFO counts and pointers wrap modulo depth. Full and empty are distinguished by an extra pointer bit.
- Reset mid-frame: tx returns high immediately and the partial frame is discarded.

Test Plan:
- CLK_DIV=4, write 0x55 to addr 0 at edge E -> tx=0 over E+1..E+4, then 1,0,1,0,1,0,1,0 for 4 clocks each, then stop=1; tx_empty=1 at E+41.
- Write 9 bytes back-to-back with TX_DEPTH=8 and no gap -> first byte popped, all 9 transmitted with no idle between stop and start bits. Then write 10 bytes while tx is busy -> tx_ovf=1 (STATUS bit5); write 0x20 to addr 1 -> bit5 clears.
- Drive an rx frame 0xA3 at CLK_DIV=4 -> STATUS bit2=1; a read of addr 0 returns 0xA3 on the next edge, and STATUS bit2=0 afterwards.
- rx frame with stop bit 0 -> frm_err=1 and RX FIFO still empty. A 1-cycle low glitch on rx -> no byte and no error.
- Receive 9 frames with RX_DEPTH=8 and no reads -> rx_ovr=1 and the first 8 bytes read back in order. IEN=0x01 -> irq=1 while data is pending and 0 after the last read.
- Assert rst midway through a TX data bit -> tx=1 immediately, STATUS=0x02 after release, no residual transmission.
